// File: rtl/sram_loader.sv
// sram_loader: receives a length-prefixed word stream from a UART receiver and
// writes it into an asynchronous SRAM page, then pulses go_load to start the
// boot-to-run stage.
// Optional feature: define SRAM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit additive checksum over all data bytes before go_load is issued.
module sram_loader #(
  parameter int WE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  page,
  output logic [15:0] SRAM_ADDR,
  output logic [15:0] SRAM_DOUT,
  output logic        SRAM_WE_n,
  output logic        busy,
  output logic        done,
  output logic        go_load,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_GO,
    S_DONE,
    S_ERR
`ifdef SRAM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  // State entered once the last word has been written (or when N is zero).
`ifdef SRAM_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHECK;
`else
  localparam state_t S_FINISH = S_GO;
`endif

  localparam logic [3:0]  WE_LAST = 4'(WE_CYCLES - 1);
  localparam logic [15:0] MAX_WORDS = 16'd256;

  state_t      state;
  state_t      nxt;
  logic [15:0] len;
  logic [7:0]  len_hi;
  logic [7:0]  hi_byte;
  logic [8:0]  idx;
  logic [8:0]  idx_inc;
  logic [3:0]  we_cnt;
  logic        accept;
  logic        rx_nxt;
  logic [15:0] len_rx;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Next-state decode and acceptance handshake.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt     = state;
    accept  = rx_valid & rx_ready;
    len_rx  = {len_hi, rx_data};
    idx_inc = idx + 9'd1;
    case (state)
      S_IDLE:     if (accept) nxt = S_LEN_LO;
      S_LEN_LO:   if (accept) begin
                    if (len_rx > MAX_WORDS)  nxt = S_ERR;
                    else if (len_rx == 16'd0) nxt = S_FINISH;
                    else                      nxt = S_DATA_HI;
                  end
      S_DATA_HI:  if (accept) nxt = S_DATA_LO;
      S_DATA_LO:  if (accept) nxt = S_WR_SETUP;
      S_WR_SETUP: nxt = S_WR_PULSE;
      S_WR_PULSE: if (we_cnt == WE_LAST) nxt = S_WR_HOLD;
      S_WR_HOLD:  nxt = ({7'd0, idx_inc} == len) ? S_FINISH : S_DATA_HI;
`ifdef SRAM_LOADER_CHECKSUM_EN
      S_CHECK:    if (accept) nxt = (rx_data == csum) ? S_GO : S_ERR;
`endif
      S_GO:       nxt = S_DONE;
      S_DONE:     nxt = S_DONE;
      S_ERR:      nxt = S_ERR;
      default:    nxt = S_IDLE;
    endcase
    rx_nxt = (nxt == S_IDLE) || (nxt == S_LEN_LO) ||
             (nxt == S_DATA_HI) || (nxt == S_DATA_LO);
`ifdef SRAM_LOADER_CHECKSUM_EN
    rx_nxt = rx_nxt || (nxt == S_CHECK);
`endif
  end

  // State, registered outputs decoded from the next state, and datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      len_hi    <= '0;
      hi_byte   <= '0;
      idx       <= '0;
      we_cnt    <= '0;
      SRAM_ADDR <= '0;
      SRAM_DOUT <= '0;
      SRAM_WE_n <= 1'b1;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      go_load   <= 1'b0;
      err       <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= nxt;
      rx_ready  <= rx_nxt;
      busy      <= !((nxt == S_IDLE) || (nxt == S_DONE) || (nxt == S_ERR));
      done      <= (nxt == S_DONE);
      err       <= (nxt == S_ERR);
      go_load   <= (nxt == S_GO);
      SRAM_WE_n <= (nxt != S_WR_PULSE);
      case (state)
        S_IDLE:     if (accept) len_hi <= rx_data;
        S_LEN_LO:   if (accept) begin
                      len <= len_rx;
                      idx <= '0;
                    end
        S_DATA_HI:  if (accept) begin
                      hi_byte <= rx_data;
`ifdef SRAM_LOADER_CHECKSUM_EN
                      csum    <= csum + rx_data;
`endif
                    end
        S_DATA_LO:  if (accept) begin
                      // page is sampled here so the address is fixed for the write.
                      SRAM_ADDR <= {page, idx[7:0]};
                      SRAM_DOUT <= {hi_byte, rx_data};
`ifdef SRAM_LOADER_CHECKSUM_EN
                      csum      <= csum + rx_data;
`endif
                    end
        S_WR_SETUP: we_cnt <= '0;
        S_WR_PULSE: we_cnt <= we_cnt + 4'd1;
        S_WR_HOLD:  idx <= idx_inc;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: directed bench for sram_loader with a write scoreboard.
// Honors SRAM_LOADER_CHECKSUM_EN the same way the design does.
module tb_sram_loader;

  localparam int WE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  page = '0;
  logic        rx_ready;
  logic [15:0] SRAM_ADDR;
  logic [15:0] SRAM_DOUT;
  logic        SRAM_WE_n;
  logic        busy;
  logic        done;
  logic        go_load;
  logic        err;

  sram_loader #(.WE_CYCLES(WE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .page      (page),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DOUT (SRAM_DOUT),
    .SRAM_WE_n (SRAM_WE_n),
    .busy      (busy),
    .done      (done),
    .go_load   (go_load),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_writes = 0;
  int          go_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tb_sum;
  logic [7:0]  tb_idx;
  int          st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a byte from a negedge and hold it until accepted; returns the
  // number of negedges spent waiting for rx_ready.
  task automatic send_byte(input logic [7:0] b, output int stalls);
    rx_data  = b;
    rx_valid = 1'b1;
    stalls   = 0;
    while (rx_ready !== 1'b1 && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 200) begin
      check("accept_timeout", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, output int stalls);
    int dummy;
    exp_q.push_back({page, tb_idx, w});
    tb_idx = tb_idx + 8'd1;
    tb_sum = tb_sum + w[15:8] + w[7:0];
    send_byte(w[15:8], stalls);
    send_byte(w[7:0], dummy);
  endtask

  task automatic start_load(input logic [15:0] n);
    int dummy;
    tb_idx = '0;
    tb_sum = '0;
    send_byte(n[15:8], dummy);
    send_byte(n[7:0], dummy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    go_cnt   = 0;
    n_writes = 0;
    rst_n    = 1'b1;
    @(negedge clk);
  endtask

  // Write monitor: measures each WE_n pulse and scores it against the queue.
  initial begin : monitor
    bit          in_pulse = 1'b0;
    int          low_cnt = 0;
    logic [15:0] cap_addr;
    logic [15:0] cap_data;
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 1'b0;
      end else begin
        if (go_load) go_cnt++;
        if (!SRAM_WE_n) begin
          check("rdy_in_write", {31'd0, rx_ready}, 32'd0);
          if (!in_pulse) begin
            in_pulse = 1'b1;
            low_cnt  = 1;
            cap_addr = SRAM_ADDR;
            cap_data = SRAM_DOUT;
          end else begin
            low_cnt++;
            check("addr_data_stable", {SRAM_ADDR, SRAM_DOUT}, {cap_addr, cap_data});
          end
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          n_writes++;
          check("we_width", low_cnt, WE);
          check("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check("write_addr_data", {SRAM_ADDR, SRAM_DOUT}, exp_w);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held across clock edges.
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {rx_ready, SRAM_WE_n, busy, done, go_load, err},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("rst_addr_data", {SRAM_ADDR, SRAM_DOUT}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready_rise", {31'd0, rx_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic load with backpressure on the second word's high byte.
    page = 8'h12;
    start_load(16'd2);
    check("busy_loading", {31'd0, busy}, 32'd1);
    send_word(16'hABCD, st);
    send_word(16'h1234, st);
    check("backpressure_stalls", st, WE + 2);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(tb_sum, st);
`endif
    repeat (WE + 4) @(negedge clk);
    #1;
    check("basic_writes", n_writes, 2);
    check("basic_go_once", go_cnt, 1);
    check("basic_done", {busy, done, err}, {1'b0, 1'b1, 1'b0});
    check("basic_q_empty", exp_q.size(), 0);
    // Bytes offered in DONE are ignored.
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("done_no_accept", {rx_ready, done, go_load}, {1'b0, 1'b1, 1'b0});
    check("done_no_writes", n_writes, 2);
    rx_valid = 1'b0;

    // Zero length.
    do_reset();
    start_load(16'd0);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, st);
`endif
    repeat (2) @(negedge clk);
    #1;
    check("zero_go", go_cnt, 1);
    check("zero_done", {done, err}, {1'b1, 1'b0});
    check("zero_writes", n_writes, 0);

    // Oversize length.
    do_reset();
    start_load(16'h0101);
    check("over_err", {err, rx_ready, busy}, {1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    #1;
    check("over_quiet", {n_writes[15:0], go_cnt[14:0], SRAM_WE_n}, {16'd0, 15'd0, 1'b1});
    check("over_sticky", {err, done}, {1'b1, 1'b0});

    // Reset asserted during WR_PULSE.
    do_reset();
    page = 8'h40;
    start_load(16'd1);
    send_byte(8'h11, st);
    send_byte(8'h22, st);
    repeat (2) @(negedge clk);
    #2;
    check("pulse_active", {31'd0, SRAM_WE_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {rx_ready, SRAM_WE_n, busy, done, go_load, err},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("async_rst_addr_data", {SRAM_ADDR, SRAM_DOUT}, 32'd0);
    repeat (2) @(negedge clk);
    go_cnt   = 0;
    n_writes = 0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rx_ready_rise2", {31'd0, rx_ready}, 32'd1);
    page = 8'h12;
    start_load(16'd3);
    send_word(16'h5A5A, st);
    send_word(16'h0001, st);
    send_word(16'hFFFF, st);
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_byte(tb_sum, st);
`endif
    repeat (WE + 4) @(negedge clk);
    #1;
    check("fresh_writes", n_writes, 3);
    check("fresh_go_done", {go_cnt[30:0], done}, {31'd1, 1'b1});
    check("fresh_q_empty", exp_q.size(), 0);

`ifdef SRAM_LOADER_CHECKSUM_EN
    // Checksum mismatch: writes happen, but no go_load.
    do_reset();
    page = 8'h12;
    start_load(16'd2);
    send_word(16'hABCD, st);
    send_word(16'h1234, st);
    send_byte(tb_sum + 8'd1, st);
    repeat (3) @(negedge clk);
    #1;
    check("csum_err", {err, done, busy}, {1'b1, 1'b0, 1'b0});
    check("csum_no_go", go_cnt, 0);
    check("csum_writes", n_writes, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
